// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM encoding,
// digit-adjust constants and the output sizing check.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W = 4;

    // A digit at or above the threshold would pass 9 after the next shift.
    localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESHOLD = 4'd5;
    localparam logic [BCD_DIGIT_W-1:0] ADJ_CONST     = 4'd3;

    // True when DIGITS decimal digits can hold every WIDTH-bit unsigned
    // value, i.e. 10^digits > 2^width - 1.
    function automatic bit digits_fit(input int width, input int digits);
        longint unsigned pow10;
        longint unsigned max_bin;
        pow10 = 64'd1;
        for (int i = 0; i < digits; i++) begin
            pow10 = pow10 * 64'd10;
        end
        max_bin = (64'd1 << width) - 64'd1;
        return pow10 > max_bin;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets +3
// before the shift so that it carries correctly into the next digit.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    // Conditional add-3, 4-bit wrap; the input range 0..9 never overflows.
    assign dout = (din >= ADJ_THRESHOLD) ? din + ADJ_CONST : din;

endmodule

// File: rtl/bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3). Accepts one value
// in IDLE, spends WIDTH cycles in CONV, then pulses out_valid in DONE while
// presenting registered digits and a leading-zero blanking mask.
module bcd_converter
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
)
(
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    output logic                          busy,
    output logic [BCD_DIGIT_W*DIGITS-1:0] digits,
    output logic [DIGITS-1:0]             digit_nz
);

    localparam int ACC_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int PAIR_W = ACC_W + WIDTH;
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(1);
    localparam logic [DIGITS-1:0] NZ_RESET = DIGITS'(1);

    // Refuse to build a converter whose accumulator could overflow.
    if (!digits_fit(WIDTH, DIGITS)) begin : g_size_check
        $fatal(1, "bcd_converter: DIGITS too small for WIDTH");
    end

    state_t              state;
    logic [WIDTH-1:0]    shift_reg;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_adj;
    logic [ACC_W-1:0]    acc_next;
    logic [WIDTH-1:0]    shift_next;
    logic [PAIR_W-1:0]   pair_next;
    logic [CNT_W-1:0]    count;
    logic [DIGITS-1:0]   nz_next;
    logic                nz_seen;

    // One add-3 cell per accumulator digit.
    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        bcd_digit_adjust u_adj (
            .din  (acc[k*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout (acc_adj[k*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Shift the corrected {accumulator, shift register} pair left by one.
    assign pair_next  = {acc_adj, shift_reg} << 1;
    assign acc_next   = pair_next[PAIR_W-1:WIDTH];
    assign shift_next = pair_next[WIDTH-1:0];

    // Leading-zero mask of the value about to be latched; units always shown.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        nz_seen = 1'b0;
        nz_next = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            nz_seen    = nz_seen | (acc_next[k*BCD_DIGIT_W +: BCD_DIGIT_W] != '0);
            nz_next[k] = nz_seen;
        end
        nz_next[0] = 1'b1;
    end

    // Control FSM and conversion datapath.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: datapath registers are reset too so a discarded conversion
            // leaves no stale value behind; there is no memory array here.
            state     <= ST_IDLE;
            shift_reg <= '0;
            acc       <= '0;
            count     <= '0;
            digits    <= '0;
            digit_nz  <= NZ_RESET;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        shift_reg <= in_data;
                        acc       <= '0;
                        count     <= CNT_INIT;
                        state     <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    acc       <= acc_next;
                    shift_reg <= shift_next;
                    count     <= count - CNT_LAST;
                    if (count == CNT_LAST) begin
                        digits   <= acc_next;
                        digit_nz <= nz_next;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake and status are pure decodes of the registered state.
    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign out_valid = (state == ST_DONE);

endmodule
